// File: rtl/int_dispatcher.sv
// -----------------------------------------------------------------------------
// int_dispatcher
//
// Sequences CPU interrupt servicing against the pending & enabled vector coming
// from the IE/IF controller. Owns the interrupt master enable (IME), the
// one-instruction EI delay, HALT wake-up and the HALT bug, and runs the
// five M-cycle dispatch: two wait cycles, push PC high, push PC low, jump.
//
// Ports
//   clk, reset       clock, synchronous active-high reset
//   cpu_en           M-cycle enable; every state change happens only when 1
//   ints[4:0]        pending & enabled interrupts, bit0 highest priority
//   int_ack          acknowledge to IF (controller clears lowest set bit)
//   instr_boundary   current M-cycle ends an instruction
//   ei, di, reti     decoded strobes, valid on the instruction's final M-cycle
//   halt             HALT decoded strobe, valid with instr_boundary
//   pc, sp           current PC (return address) and SP
//   bus_addr/bus_wdata/bus_write   stack push interface
//   sp_dec           CPU decrements SP at the end of this M-cycle
//   pc_load          CPU loads pc_vector at the end of this M-cycle
//   pc_vector        dispatch target
//   busy             dispatch in progress; CPU stalls fetch/execute
//   halted           CPU halted
//   halt_bug         one-cycle pulse: CPU skips its next PC increment
//   ime              interrupt master enable
//   dbg_state        current sequencer state, for observation only
//
// Strobe semantics: int_ack, bus_write, sp_dec, pc_load and halt_bug are
// single-cycle commands that take effect at the clock edge that ends the
// cycle in which they are high. They are only ever high when cpu_en=1 and
// reset=0; there is no back-pressure, the receiver must act on every one.
// -----------------------------------------------------------------------------
module int_dispatcher #(
  parameter logic [15:0] VEC_BASE = 16'h0040,
  parameter logic [15:0] VEC_NONE = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_en,
  input  logic [4:0]  ints,
  output logic        int_ack,
  input  logic        instr_boundary,
  input  logic        ei,
  input  logic        di,
  input  logic        reti,
  input  logic        halt,
  input  logic [15:0] pc,
  input  logic [15:0] sp,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        bus_write,
  output logic        sp_dec,
  output logic        pc_load,
  output logic [15:0] pc_vector,
  output logic        busy,
  output logic        halted,
  output logic        halt_bug,
  output logic        ime,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT1   = 3'd1,
    S_WAIT2   = 3'd2,
    S_PUSH_HI = 3'd3,
    S_PUSH_LO = 3'd4,
    S_JUMP    = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        ime_q, ime_d;
  logic        ei_pend_q, ei_pend_d;
  logic        halted_q, halted_d;
  logic [15:0] vec_q, vec_d;

  logic        int_any;
  logic        exec_cycle;
  logic        ime_eff;
  logic        dispatch_start;
  logic        strobe_en;
  logic [15:0] vec_sel;

  assign int_any   = |ints;
  // Strobes are suppressed in a reset cycle so an aborted dispatch never
  // touches the bus or the IF register.
  assign strobe_en = cpu_en & ~reset;

  // An enabled cycle in which the CPU is actually executing instructions.
  assign exec_cycle = cpu_en & (state_q == S_IDLE) & ~halted_q;

  // IME as seen at this boundary: a pending EI or a RETI takes effect right
  // here, DI overrides everything.
  assign ime_eff = (ime_q | (ei_pend_q & instr_boundary) | reti) & ~di;

  // A dispatch takes priority over whatever the boundary instruction would
  // otherwise do to IME/HALT state (a HALT seeing IME=1 and a pending
  // interrupt is serviced immediately instead of halting).
  assign dispatch_start = exec_cycle & instr_boundary & ime_eff & int_any;

  // Vector of the lowest set bit; VEC_NONE when nothing is pending.
  always_comb begin
    vec_sel = VEC_NONE;
    for (int i = 4; i >= 0; i--) begin
      if (ints[i]) vec_sel = VEC_BASE + 16'(8 * i);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ime_q     <= 1'b0;
      ei_pend_q <= 1'b0;
      halted_q  <= 1'b0;
      vec_q     <= 16'h0000;
    end else begin
      state_q   <= state_d;
      ime_q     <= ime_d;
      ei_pend_q <= ei_pend_d;
      halted_q  <= halted_d;
      vec_q     <= vec_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    ime_d     = ime_q;
    ei_pend_d = ei_pend_q;
    halted_d  = halted_q;
    vec_d     = vec_q;
    if (cpu_en) begin
      case (state_q)
        S_IDLE: begin
          if (halted_q) begin
            // Any pending interrupt wakes the CPU; it is serviced only if IME.
            if (int_any) begin
              halted_d = 1'b0;
              if (ime_q) begin
                state_d   = S_WAIT1;
                ime_d     = 1'b0;
                ei_pend_d = 1'b0;
              end
            end
          end else if (instr_boundary) begin
            if (dispatch_start) begin
              state_d   = S_WAIT1;
              ime_d     = 1'b0;
              ei_pend_d = 1'b0;
            end else if (di) begin
              ime_d     = 1'b0;
              ei_pend_d = 1'b0;
            end else begin
              if (reti || ei_pend_q) ime_d = 1'b1;
              // A pending EI is consumed here; a new EI re-arms it.
              ei_pend_d = ei;
              // HALT with IME=0 and a pending interrupt does not halt (bug).
              if (halt && (ime_q || !int_any)) halted_d = 1'b1;
            end
          end
        end
        S_WAIT1:   state_d = S_WAIT2;
        S_WAIT2:   state_d = S_PUSH_HI;
        S_PUSH_HI: state_d = S_PUSH_LO;
        S_PUSH_LO: begin
          // Sampled late so an IE write during PUSH_HI can cancel/redirect.
          vec_d   = vec_sel;
          state_d = S_JUMP;
        end
        S_JUMP:    state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    int_ack   = 1'b0;
    bus_write = 1'b0;
    sp_dec    = 1'b0;
    pc_load   = 1'b0;
    halt_bug  = 1'b0;
    bus_addr  = 16'h0000;
    bus_wdata = 8'h00;
    case (state_q)
      S_IDLE: begin
        halt_bug = strobe_en & ~halted_q & instr_boundary & halt & ~ime_q
                   & int_any & ~dispatch_start;
      end
      S_PUSH_HI: begin
        bus_addr  = sp - 16'd1;
        bus_wdata = pc[15:8];
        bus_write = strobe_en;
        sp_dec    = strobe_en;
      end
      S_PUSH_LO: begin
        // SP was already decremented by the CPU after PUSH_HI.
        bus_addr  = sp - 16'd1;
        bus_wdata = pc[7:0];
        bus_write = strobe_en;
        sp_dec    = strobe_en;
        int_ack   = strobe_en & int_any;
      end
      S_JUMP: begin
        pc_load = strobe_en;
      end
      default: begin
        int_ack = 1'b0;
      end
    endcase
  end

  assign pc_vector = vec_q;
  assign busy      = (state_q != S_IDLE);
  assign halted    = halted_q;
  assign ime       = ime_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_int_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_int_dispatcher
//
// The bench plays the CPU (owns PC/SP, reacts to sp_dec/pc_load) and the IE/IF
// controller (owns IE/IF, clears the lowest pending bit on int_ack). A
// behavioural model of IME / EI delay / HALT decides, per instruction, what
// the dispatcher must emit; expected strobe cycles go into exp_q and a
// separate monitor compares every strobe cycle the DUT produces.
// -----------------------------------------------------------------------------
module tb_int_dispatcher;

  localparam int W = 36;  // {write, ack, load, bug, addr[15:0], data[15:0]}

  logic        clk;
  logic        reset;
  logic        cpu_en;
  logic [4:0]  ints;
  logic        int_ack;
  logic        instr_boundary;
  logic        ei;
  logic        di;
  logic        reti;
  logic        halt;
  logic [15:0] pc;
  logic [15:0] sp;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_write;
  logic        sp_dec;
  logic        pc_load;
  logic [15:0] pc_vector;
  logic        busy;
  logic        halted;
  logic        halt_bug;
  logic        ime;
  logic [2:0]  dbg_state;

  logic [4:0]  if_reg;
  logic [4:0]  ie_reg;
  assign ints = if_reg & ie_reg;

  int_dispatcher dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_en         (cpu_en),
    .ints           (ints),
    .int_ack        (int_ack),
    .instr_boundary (instr_boundary),
    .ei             (ei),
    .di             (di),
    .reti           (reti),
    .halt           (halt),
    .pc             (pc),
    .sp             (sp),
    .bus_addr       (bus_addr),
    .bus_wdata      (bus_wdata),
    .bus_write      (bus_write),
    .sp_dec         (sp_dec),
    .pc_load        (pc_load),
    .pc_vector      (pc_vector),
    .busy           (busy),
    .halted         (halted),
    .halt_bug       (halt_bug),
    .ime            (ime),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [15:0]  last_vec = 16'h0000;
  int           ack_cnt = 0;
  int           bug_cnt = 0;
  logic         busy_s;

  // reference model
  typedef enum int {I_NOP, I_EI, I_DI, I_RETI, I_HALT} op_t;
  bit m_ime, m_ei_pend, m_halted;

  function automatic logic [W-1:0] ev(input logic w, input logic a, input logic l,
                                      input logic b, input logic [15:0] addr,
                                      input logic [15:0] data);
    return {w, a, l, b, addr, data};
  endfunction

  function automatic logic [4:0] lowbit(input logic [4:0] x);
    return x & (~x + 5'd1);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    logic [W-1:0] obs;
    logic [W-1:0] e;
    if (bus_write || int_ack || pc_load || halt_bug) begin
      obs = {bus_write, int_ack, pc_load, halt_bug,
             bus_write ? bus_addr : 16'h0000,
             bus_write ? {8'h00, bus_wdata} : (pc_load ? pc_vector : 16'h0000)};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event got %h expected none", obs);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) begin
          errors++;
          $display("FAIL event got %h expected %h", obs, e);
        end
      end
      if (pc_load) last_vec = pc_vector;
      if (int_ack) ack_cnt++;
      if (halt_bug) bug_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  // One clock. The bench acts on int_ack / sp_dec at the edge, like the
  // real IF controller and CPU would.
  task automatic tick();
    logic ack_s, dec_s;
    @(negedge clk);
    ack_s  = int_ack;
    dec_s  = sp_dec;
    busy_s = busy;
    @(posedge clk);
    #1;
    if (ack_s) if_reg = if_reg & ~lowbit(if_reg & ie_reg);
    if (dec_s) sp = sp - 16'd1;
  endtask

  // One enabled M-cycle, preceded by 0..2 stalled cycles with no strobes.
  task automatic mcycle();
    logic [4:0] s;
    int gaps;
    s = {instr_boundary, ei, di, reti, halt};
    {instr_boundary, ei, di, reti, halt} = 5'b0;
    cpu_en = 1'b0;
    gaps = $urandom_range(0, 2);
    for (int g = 0; g < gaps; g++) tick();
    {instr_boundary, ei, di, reti, halt} = s;
    cpu_en = 1'b1;
    tick();
    cpu_en = 1'b0;
    {instr_boundary, ei, di, reti, halt} = 5'b0;
  endtask

  // Called with the DUT in WAIT1. Optionally rewrites IE at the end of PUSH_HI.
  task automatic run_dispatch(input bit ie_mode, input logic [4:0] ie_new);
    int          busy_cnt;
    logic [15:0] ret_pc, sp0, vec;
    logic [4:0]  pend;
    int          idx;
    busy_cnt = 0;
    ret_pc   = pc;
    sp0      = sp;
    mcycle(); busy_cnt += int'(busy_s);   // WAIT1
    mcycle(); busy_cnt += int'(busy_s);   // WAIT2
    exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 1'b0, sp - 16'd1, {8'h00, ret_pc[15:8]}));
    mcycle(); busy_cnt += int'(busy_s);   // PUSH_HI
    if (ie_mode) ie_reg = ie_new;
    pend = if_reg & ie_reg;
    idx = -1;
    for (int i = 4; i >= 0; i--) if (pend[i]) idx = i;
    vec = (idx < 0) ? 16'h0000 : 16'h0040 + 16'(8 * idx);
    exp_q.push_back(ev(1'b1, pend != 5'b0, 1'b0, 1'b0, sp - 16'd1, {8'h00, ret_pc[7:0]}));
    mcycle(); busy_cnt += int'(busy_s);   // PUSH_LO
    exp_q.push_back(ev(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, vec));
    mcycle(); busy_cnt += int'(busy_s);   // JUMP
    check("busy_cycles", busy_cnt, 5);
    check("busy_after_jump", {31'b0, busy}, 0);
    check("ime_after_dispatch", {31'b0, ime}, 0);
    check("sp_after_dispatch", {16'b0, sp}, {16'b0, sp0 - 16'd2});
    check("events_drained", exp_q.size(), 0);
    pc = vec;
  endtask

  // One instruction: 0..1 non-final M-cycles, then the boundary M-cycle.
  task automatic do_instr(input op_t op, input bit ie_mode, input logic [4:0] ie_new);
    logic [4:0] pend;
    bit eff, disp, ime_before;
    int pre;
    pre = $urandom_range(0, 1);
    for (int k = 0; k < pre; k++) mcycle();
    pend       = if_reg & ie_reg;
    ime_before = m_ime;
    eff  = (m_ime || m_ei_pend || op == I_RETI) && (op != I_DI);
    disp = eff && (pend != 5'b0);
    if (!disp) begin
      if (op == I_DI) begin
        m_ime = 0;
        m_ei_pend = 0;
      end else begin
        if (op == I_RETI || m_ei_pend) m_ime = 1;
        m_ei_pend = (op == I_EI);
        if (op == I_HALT) begin
          if (!ime_before && pend != 5'b0)
            exp_q.push_back(ev(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000));
          else
            m_halted = 1;
        end
      end
    end
    instr_boundary = 1'b1;
    ei   = (op == I_EI);
    di   = (op == I_DI);
    reti = (op == I_RETI);
    halt = (op == I_HALT);
    mcycle();
    if (disp) begin
      m_ime = 0;
      m_ei_pend = 0;
      run_dispatch(ie_mode, ie_new);
    end else begin
      check("no_dispatch_busy", {31'b0, busy}, 0);
      check("events_after_instr", exp_q.size(), 0);
    end
    check("ime_model", {31'b0, ime}, {31'b0, m_ime});
    check("halted_model", {31'b0, halted}, {31'b0, m_halted});
  endtask

  task automatic wake_from_halt(input logic [4:0] bits);
    bit will_disp;
    check("halted_before_wake", {31'b0, halted}, 1);
    if_reg = if_reg | bits;
    ie_reg = ie_reg | bits;
    will_disp = m_ime;
    mcycle();
    m_halted = 0;
    check("halted_after_wake", {31'b0, halted}, 0);
    if (will_disp) begin
      m_ime = 0;
      m_ei_pend = 0;
      run_dispatch(1'b0, 5'b0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acks0, bugs0;
    reset = 1'b1;
    cpu_en = 1'b0;
    {instr_boundary, ei, di, reti, halt} = 5'b0;
    if_reg = 5'b0;
    ie_reg = 5'h1f;
    pc = 16'h0100;
    sp = 16'hFFFE;
    m_ime = 0; m_ei_pend = 0; m_halted = 0;
    tick(); tick();
    reset = 1'b0;

    // reset state
    check("rst_ime", {31'b0, ime}, 0);
    check("rst_halted", {31'b0, halted}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_state", {29'b0, dbg_state}, 0);
    check("rst_pc_vector", {16'b0, pc_vector}, 0);
    check("rst_bus_addr", {16'b0, bus_addr}, 0);
    check("rst_strobes", {27'b0, bus_write, sp_dec, pc_load, int_ack, halt_bug}, 0);

    // 1: ime=1 via EI+NOP, then bit2 -> 0x0050
    do_instr(I_EI, 0, 0);
    do_instr(I_NOP, 0, 0);
    check("t1_ime_set", {31'b0, ime}, 1);
    pc = 16'h1234; sp = 16'hFFFE;
    if_reg = 5'b00100;
    do_instr(I_NOP, 0, 0);
    check("t1_vector", {16'b0, last_vec}, 32'h0050);
    check("t1_if_cleared", {27'b0, if_reg}, 0);

    // 2: RETI with 10101 -> 0x0040, 10100 remains
    if_reg = 5'b10101;
    do_instr(I_RETI, 0, 0);
    check("t2_vector", {16'b0, last_vec}, 32'h0040);
    check("t2_if_remaining", {27'b0, if_reg}, 32'h14);

    // 3: bit0 cancelled by IE write during PUSH_HI
    if_reg = 5'b00001;
    acks0 = ack_cnt;
    do_instr(I_RETI, 1, 5'b00000);
    check("t3_vector_none", {16'b0, last_vec}, 0);
    check("t3_no_ack", ack_cnt - acks0, 0);
    check("t3_if_kept", {27'b0, if_reg}, 1);
    ie_reg = 5'h1f;

    // 4: EI delay, then EI+DI
    if_reg = 5'b00010;
    do_instr(I_EI, 0, 0);
    check("t4_no_dispatch_at_ei", {31'b0, ime}, 0);
    do_instr(I_NOP, 0, 0);
    check("t4_vector", {16'b0, last_vec}, 32'h0048);
    if_reg = 5'b00010;
    acks0 = ack_cnt;
    do_instr(I_EI, 0, 0);
    do_instr(I_DI, 0, 0);
    do_instr(I_NOP, 0, 0);
    check("t4_ei_di_ime", {31'b0, ime}, 0);
    check("t4_ei_di_no_ack", ack_cnt - acks0, 0);

    // 5: HALT bug, then HALT with ime=1 and wake
    bugs0 = bug_cnt;
    do_instr(I_HALT, 0, 0);
    check("t5_bug_pulse", bug_cnt - bugs0, 1);
    check("t5_not_halted", {31'b0, halted}, 0);
    if_reg = 5'b0;
    do_instr(I_EI, 0, 0);
    do_instr(I_NOP, 0, 0);
    do_instr(I_HALT, 0, 0);
    check("t5_halted", {31'b0, halted}, 1);
    repeat (3) mcycle();
    check("t5_still_halted", {31'b0, halted}, 1);
    wake_from_halt(5'b01000);
    check("t5_vector", {16'b0, last_vec}, 32'h0058);

    // 6: reset during PUSH_HI
    if_reg = 5'b0;
    do_instr(I_EI, 0, 0);
    do_instr(I_NOP, 0, 0);
    if_reg = 5'b00100;
    instr_boundary = 1'b1;
    mcycle();                 // dispatch start -> WAIT1
    mcycle();                 // WAIT1
    mcycle();                 // WAIT2, now in PUSH_HI
    check("t6_busy_in_push", {31'b0, busy}, 1);
    reset = 1'b1;
    cpu_en = 1'b1;
    tick();
    reset = 1'b0;
    cpu_en = 1'b0;
    m_ime = 0; m_ei_pend = 0; m_halted = 0;
    check("t6_state_idle", {29'b0, dbg_state}, 0);
    check("t6_busy", {31'b0, busy}, 0);
    check("t6_ime", {31'b0, ime}, 0);
    repeat (6) mcycle();
    do_instr(I_NOP, 0, 0);
    check("t6_if_untouched", {27'b0, if_reg}, 32'h04);

    // randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      if (m_halted) begin
        int idle = $urandom_range(0, 2);
        for (int k = 0; k < idle; k++) mcycle();
        wake_from_halt(5'(1 << $urandom_range(0, 4)));
      end else begin
        int r;
        op_t op;
        if ($urandom_range(0, 3) == 0) if_reg = if_reg | 5'(1 << $urandom_range(0, 4));
        if ($urandom_range(0, 5) == 0) if_reg = 5'b0;
        if ($urandom_range(0, 9) == 0) ie_reg = 5'($urandom);
        if ($urandom_range(0, 15) == 0) sp = 16'hFFFE;
        pc = 16'($urandom);
        r = $urandom_range(0, 9);
        case (r)
          4:       op = I_EI;
          5:       op = I_DI;
          6:       op = I_RETI;
          7:       op = I_HALT;
          default: op = I_NOP;
        endcase
        do_instr(op, $urandom_range(0, 3) == 0, 5'($urandom));
      end
    end

    check("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
